// File: rtl/multdiv_pkg.sv
// Shared definitions for the multdiv issue controller: FSM state encoding,
// exception codes and the default register index used for rstatus writes.
package multdiv_pkg;

  // State encoding, fixed so the values can be referenced from outside the FSM
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_BUSY  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    START = ST_START,
    BUSY  = ST_BUSY,
    DONE  = ST_DONE
  } state_e;

  // Architectural register that receives the exception status
  localparam int MD_RSTATUS_REG    = 30;
  // rstatus values written when the multdiv unit flags an exception
  localparam int MD_MULT_EXC_CODE  = 4;
  localparam int MD_DIV_EXC_CODE   = 5;
  // Watchdog limit, only meaningful when MULTDIV_TIMEOUT_EN is defined
  localparam int MD_TIMEOUT_CYCLES = 40;

endpackage

// File: rtl/multdiv_issue_ctrl.sv
// Issue controller between the execute stage and the iterative multdiv unit.
// Captures one MULT/DIV request, fires a single start pulse, stalls the
// pipeline until the unit reports ready, then presents a one-cycle writeback
// packet. Arithmetic exceptions become a write of an exception code to the
// rstatus register.
// Optional build macro: MULTDIV_TIMEOUT_EN adds a BUSY-state watchdog that
// forces an exception writeback after TIMEOUT_CYCLES without a ready.
module multdiv_issue_ctrl
  import multdiv_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int RD_W           = 5,
  parameter int RSTATUS_REG    = MD_RSTATUS_REG,
  parameter int MULT_EXC_CODE  = MD_MULT_EXC_CODE,
  parameter int DIV_EXC_CODE   = MD_DIV_EXC_CODE,
  parameter int TIMEOUT_CYCLES = MD_TIMEOUT_CYCLES
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req_valid,
  input  logic             req_is_mult,
  input  logic             req_is_div,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [RD_W-1:0]  req_rd,
  input  logic             flush,
  output logic [WIDTH-1:0] md_operandA,
  output logic [WIDTH-1:0] md_operandB,
  output logic             md_ctrl_MULT,
  output logic             md_ctrl_DIV,
  input  logic [WIDTH-1:0] md_result,
  input  logic             md_exception,
  input  logic             md_resultRDY,
  output logic             stall,
  output logic             wb_valid,
  output logic [RD_W-1:0]  wb_rd,
  output logic [WIDTH-1:0] wb_data,
  output logic             wb_exception
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("multdiv_issue_ctrl: TIMEOUT_CYCLES must be at least 1");
  end

  state_e          state;
  logic            op_mult;      // stored op type, multiply when set
  logic [RD_W-1:0] rd_q;         // stored destination register
  logic            valid_req;    // request that actually names an operation
  logic            idle_or_done; // states in which a new request may be taken
  logic            accept;       // request registered this cycle
  logic            timeout;      // watchdog expiry in BUSY

  // Exception code for the stored operation, widened to the data bus
  function automatic logic [WIDTH-1:0] exc_code(input logic is_mult);
    return is_mult ? WIDTH'(MULT_EXC_CODE) : WIDTH'(DIV_EXC_CODE);
  endfunction

  assign valid_req    = req_valid & (req_is_mult | req_is_div);
  assign idle_or_done = (state == IDLE) | (state == DONE);
  // A flush in the same cycle wins over taking a new request
  assign accept       = idle_or_done & valid_req & ~flush;

  // Hold the pipeline while an op is in flight or waiting to be taken
  assign stall = (state == START) | (state == BUSY) | (idle_or_done & valid_req);

  // Writeback strobe follows DONE directly so a flush in DONE can still kill it
  assign wb_valid = (state == DONE) & ~flush;

`ifdef MULTDIV_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] busy_cnt;

  // Count BUSY cycles since the last issue; restarts on every new request
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_cnt <= '0;
    end else if (accept) begin
      busy_cnt <= '0;
    end else if (state == BUSY) begin
      busy_cnt <= busy_cnt + TO_W'(1);
    end
  end

  // Expire on the last permitted BUSY cycle so DONE lands TIMEOUT_CYCLES after BUSY entry
  assign timeout = (state == BUSY) & (busy_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // Issue FSM: operand capture, start pulse, result capture and writeback packet
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      op_mult      <= 1'b0;
      rd_q         <= '0;
      md_operandA  <= '0;
      md_operandB  <= '0;
      md_ctrl_MULT <= 1'b0;
      md_ctrl_DIV  <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      wb_exception <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below sees
      // this cycle's register values and the later assignment of the start
      // pulses safely overrides the default clear.
      md_ctrl_MULT <= 1'b0;
      md_ctrl_DIV  <= 1'b0;

      if (accept) begin
        md_operandA  <= req_a;
        md_operandB  <= req_b;
        rd_q         <= req_rd;
        op_mult      <= req_is_mult;
        md_ctrl_MULT <= req_is_mult;
        md_ctrl_DIV  <= ~req_is_mult;
      end

      case (state)
        IDLE, DONE: state <= accept ? START : IDLE;
        // Ready may still be high from a previous op, so it is not looked at here
        START:      state <= flush ? IDLE : BUSY;
        BUSY: begin
          if (flush) begin
            state <= IDLE;
          end else if (md_resultRDY) begin
            state        <= DONE;
            wb_rd        <= md_exception ? RD_W'(RSTATUS_REG) : rd_q;
            wb_data      <= md_exception ? exc_code(op_mult) : md_result;
            wb_exception <= md_exception;
          end else if (timeout) begin
            state        <= DONE;
            wb_rd        <= RD_W'(RSTATUS_REG);
            wb_data      <= exc_code(op_mult);
            wb_exception <= 1'b1;
          end
        end
        default:    state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/multdiv_issue_ctrl.md
Name: multdiv_issue_ctrl

Overview:
- Sequencer between the processor's execute stage and the iterative multdiv unit.
- Accepts one MULT/DIV request and registers the operands, holding them stable for the unit.
- Issues a one-cycle ctrl_MULT/ctrl_DIV start pulse and stalls the pipeline until data_resultRDY.
- Presents a single-cycle writeback packet; arithmetic exceptions are converted to an rstatus write.

Parameters:
- WIDTH, 32, operand/result width
- RD_W, 5, destination register index width
- RSTATUS_REG, 30, register written on exception
- MULT_EXC_CODE, 4, rstatus value for multiply overflow
- DIV_EXC_CODE, 5, rstatus value for divide-by-zero
- TIMEOUT_CYCLES, 40, watchdog limit (optional feature only)

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  execute stage presents a MULT/DIV op
- req_is_mult  in  1  op is multiply; wins if both flags are set
- req_is_div  in  1  op is divide
- req_a  in  WIDTH  operand A
- req_b  in  WIDTH  operand B
- req_rd  in  RD_W  destination register
- flush  in  1  abandon the in-flight op
- md_operandA  out  WIDTH  registered operand A to multdiv
- md_operandB  out  WIDTH  registered operand B to multdiv
- md_ctrl_MULT  out  1  one-cycle start pulse, multiply
- md_ctrl_DIV  out  1  one-cycle start pulse, divide
- md_result  in  WIDTH  multdiv data_result
- md_exception  in  1  multdiv data_exception
- md_resultRDY  in  1  multdiv data_resultRDY
- stall  out  1  hold upstream pipeline
- wb_valid  out  1  writeback strobe, one cycle
- wb_rd  out  RD_W  writeback register
- wb_data  out  WIDTH  writeback data
- wb_exception  out  1  writeback is an rstatus write

Behaviour:
- Reset (async, reset_n=0): state IDLE; all registered outputs 0; md_ctrl_* 0; stall 0.
- States: IDLE, START, BUSY, DONE.
- IDLE:
  - req_valid & (is_mult | is_div): register a, b, rd and op type; go to START.
  - req_valid with neither flag set: ignored.
- START: md_ctrl_MULT or md_ctrl_DIV high for exactly this one cycle; md_resultRDY is ignored here because it may be stale; go to BUSY.
- BUSY: wait for md_resultRDY=1. On that cycle capture md_result and md_exception; go to DONE.
- DONE: wb_valid=1 for exactly this one cycle.
  - No exception: wb_rd = stored rd; wb_data = captured result.
  - md_exception=1: wb_rd = RSTATUS_REG; wb_data = MULT_EXC_CODE or DIV_EXC_CODE; wb_exception=1.
  - Next state: START if a new valid request is present (back-to-back issue, operands registered that cycle), otherwise IDLE.
- stall (combinational) = START | BUSY | (IDLE & valid req) | (DONE & valid req).
- Minimum latency, request to wb_valid = 1 (accept) + 1 (START) + N (multdiv busy) + 1 (DONE).
- md_operandA/B change only on request acceptance; they are otherwise held through START/BUSY.
- wb_rd/wb_data hold their last value after wb_valid drops.
- flush:
  - In START/BUSY: go to IDLE; no wb_valid. A late md_resultRDY is ignored because state is IDLE. The next start pulse restarts multdiv.
  - In DONE: suppresses wb_valid.
  - Takes priority over acceptance in the same cycle.
- reset_n asserted mid-operation: immediate return to IDLE; no wb_valid is generated.

Optional Feature:
- Macro MULTDIV_TIMEOUT_EN.
- Defined: a counter runs in BUSY. If TIMEOUT_CYCLES elapse without md_resultRDY, go to DONE with wb_exception=1, wb_rd=RSTATUS_REG and wb_data = op's exception code. The counter clears on every entry to START.
- Undefined: BUSY waits indefinitely; no counter logic is present.

Decomposition:
- Package multdiv_pkg holds: state encoding localparams (IDLE=0, START=1, BUSY=2, DONE=3); exception codes; RSTATUS_REG.
- No sub-module. The watchdog counter is inline under the macro.

Test Plan:
- MULT a=-1, b=-1, rd=5: one md_ctrl_MULT pulse, stall high until DONE; wb_valid once with wb_rd=5, wb_data=1, wb_exception=0.
- MULT a=0x7FFFFFFF, b=2, model asserts md_exception: wb_rd=30, wb_data=4, wb_exception=1.
- DIV a=100, b=0 with exception: wb_rd=30, wb_data=5. DIV a=-100, b=7: wb_data=-14, rd preserved.
- Back-to-back: second request held valid during DONE of the first. Required: first wb_valid, next cycle START pulse for the second; no cycle with stall=0 and the request dropped.
- flush during BUSY, then model raises rdy 3 cycles later: no wb_valid; state IDLE. A following MULT 3*4 gives wb_data=12.
- reset_n low mid-BUSY then released: all outputs 0. With MULTDIV_TIMEOUT_EN and rdy never asserted, wb_exception=1 exactly TIMEOUT_CYCLES after entering BUSY.
